// File: rtl/spu_pkg.sv
// Shared widths and the write-back stage entry type for the SPU write-back pipe.
package spu_pkg;

  localparam int REG_ADDR_W       = 7;
  localparam int REG_DATA_W       = 128;
  localparam int NUM_REGS         = 128;
  localparam int WB_DEPTH_DEFAULT = 7;
  localparam int LAT_W            = 3;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_lane.sv
// One write-back lane: a DEPTH-stage shift register with latency-indexed insertion.
// With WB_SCOREBOARD_EN defined, the per-stage destination addresses are exported.
module wb_lane
  import spu_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_i,
  input  logic                             in_valid_i,
  input  logic [REG_ADDR_W-1:0]            in_rt_i,
  input  logic [REG_DATA_W-1:0]            in_data_i,
  input  logic [LAT_W-1:0]                 in_lat_i,
  output wb_entry_t                        head_o,
  output logic [DEPTH-1:0]                 valid_o,
`ifdef WB_SCOREBOARD_EN
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] rt_o,
`endif
  output logic                             collision_o,
  output logic                             lat_err_o
);

  wb_entry_t [DEPTH-1:0] stage_q, stage_d;
  logic                  collision_q, collision_d;
  logic                  lat_err_q, lat_err_d;
  logic                  lat_ok;
  int                    tgt;

  // Index 0 is S1; an entry of latency L lands at index DEPTH-L so it reaches
  // the head after exactly L edges. An older entry shifting into that slot wins.
  always_comb begin
    stage_d     = '0;
    collision_d = 1'b0;
    lat_err_d   = 1'b0;
    lat_ok      = (in_lat_i != '0) && (int'(in_lat_i) <= DEPTH);
    tgt         = DEPTH - int'(in_lat_i);
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
    if (!flush_i && in_valid_i) begin
      if (!lat_ok) begin
        lat_err_d = 1'b1;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (k == tgt) begin
            if (stage_d[k].valid) begin
              collision_d = 1'b1;
            end else begin
              stage_d[k] = '{valid: 1'b1, rt: in_rt_i, data: in_data_i};
            end
          end
        end
      end
    end
    if (flush_i) begin
      stage_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q     <= '0;
      collision_q <= 1'b0;
      lat_err_q   <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      collision_q <= collision_d;
      lat_err_q   <= lat_err_d;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      valid_o[k] = stage_q[k].valid;
    end
  end

`ifdef WB_SCOREBOARD_EN
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      rt_o[k] = stage_q[k].rt;
    end
  end
`endif

  assign head_o      = stage_q[DEPTH-1];
  assign collision_o = collision_q;
  assign lat_err_o   = lat_err_q;

endmodule

// File: rtl/wb_pipe.sv
// Dual-lane result write-back pipe with same-address arbitration (lane 1 wins).
// Optional feature macro WB_SCOREBOARD_EN adds the 'pending' register scoreboard output.
module wb_pipe
  import spu_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid_0,
  input  logic                  in_valid_1,
  input  logic [REG_ADDR_W-1:0] in_rt_0,
  input  logic [REG_ADDR_W-1:0] in_rt_1,
  input  logic [REG_DATA_W-1:0] in_data_0,
  input  logic [REG_DATA_W-1:0] in_data_1,
  input  logic [LAT_W-1:0]      in_lat_0,
  input  logic [LAT_W-1:0]      in_lat_1,
  output logic                  reg_write_en_1,
  output logic                  reg_write_en_2,
  output logic [REG_ADDR_W-1:0] reg_write_addr_1,
  output logic [REG_ADDR_W-1:0] reg_write_addr_2,
  output logic [REG_DATA_W-1:0] reg_write_data_1,
  output logic [REG_DATA_W-1:0] reg_write_data_2,
`ifdef WB_SCOREBOARD_EN
  output logic [NUM_REGS-1:0]   pending,
`endif
  output logic                  busy,
  output logic                  collision_err,
  output logic                  lat_err
);

  wb_entry_t        head0, head1;
  logic [DEPTH-1:0] valid0, valid1;
  logic             coll0, coll1, lerr0, lerr1;
  logic             sameAddr;
`ifdef WB_SCOREBOARD_EN
  logic [DEPTH-1:0][REG_ADDR_W-1:0] rt0, rt1;
`endif

  wb_lane #(.DEPTH(DEPTH)) u_lane0 (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid_0),
    .in_rt_i     (in_rt_0),
    .in_data_i   (in_data_0),
    .in_lat_i    (in_lat_0),
    .head_o      (head0),
    .valid_o     (valid0),
`ifdef WB_SCOREBOARD_EN
    .rt_o        (rt0),
`endif
    .collision_o (coll0),
    .lat_err_o   (lerr0)
  );

  wb_lane #(.DEPTH(DEPTH)) u_lane1 (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid_1),
    .in_rt_i     (in_rt_1),
    .in_data_i   (in_data_1),
    .in_lat_i    (in_lat_1),
    .head_o      (head1),
    .valid_o     (valid1),
`ifdef WB_SCOREBOARD_EN
    .rt_o        (rt1),
`endif
    .collision_o (coll1),
    .lat_err_o   (lerr1)
  );

  // Lane 1 carries the younger result, so it overrides lane 0 on an address clash.
  assign sameAddr         = head0.valid && head1.valid && (head0.rt == head1.rt);
  assign reg_write_en_1   = head0.valid && !sameAddr;
  assign reg_write_en_2   = head1.valid;
  assign reg_write_addr_1 = reg_write_en_1 ? head0.rt   : '0;
  assign reg_write_data_1 = reg_write_en_1 ? head0.data : '0;
  assign reg_write_addr_2 = reg_write_en_2 ? head1.rt   : '0;
  assign reg_write_data_2 = reg_write_en_2 ? head1.data : '0;

  assign busy          = (|valid0) || (|valid1);
  assign collision_err = coll0 || coll1;
  assign lat_err       = lerr0 || lerr1;

`ifdef WB_SCOREBOARD_EN
  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid0[k]) pending[rt0[k]] = 1'b1;
      if (valid1[k]) pending[rt1[k]] = 1'b1;
    end
  end
`endif

endmodule
